// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and PC+4, applies hazard-unit
// stall/flush, and tags each decode-stage slot with valid, delay-slot and fetch AdEL state.
module if_id_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [4:0]  ADEL_CODE = 5'h04
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [WIDTH-1:0] PC_add_4F,
    input  logic [WIDTH-1:0] InstrF,
    input  logic             BranchD,
    input  logic             JumpD,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PC_add_4D,
    output logic [WIDTH-1:0] PCD,
    output logic             ValidD,
    output logic             InDelaySlotD,
    output logic             ExcD,
    output logic [4:0]       ExcCodeD,
    output logic [WIDTH-1:0] BadVAddrD
);

    localparam int unsigned EXC_W = 5;

    logic [WIDTH-1:0] instr_q,     instr_d;
    logic [WIDTH-1:0] pc_add_4_q,  pc_add_4_d;
    logic [WIDTH-1:0] pc_q,        pc_d;
    logic             valid_q,     valid_d;
    logic             delay_q,     delay_d;
    logic             exc_q,       exc_d;
    logic [EXC_W-1:0] exc_code_q,  exc_code_d;
    logic [WIDTH-1:0] bad_vaddr_q, bad_vaddr_d;

    logic [WIDTH-1:0] pc_f;
    logic             misaligned_f;

    // PC of the fetched word wraps modulo 2^WIDTH, so PC+4 of 0 maps to the top of memory.
    assign pc_f         = PC_add_4F - WIDTH'(4);
    assign misaligned_f = |pc_f[1:0];

    // Next-state: flush beats stall beats load.
    always_comb begin
        instr_d     = instr_q;
        pc_add_4_d  = pc_add_4_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        delay_d     = delay_q;
        exc_d       = exc_q;
        exc_code_d  = exc_code_q;
        bad_vaddr_d = bad_vaddr_q;

        if (FlushD) begin
            instr_d     = '0;
            pc_add_4_d  = '0;
            pc_d        = '0;
            valid_d     = 1'b0;
            delay_d     = 1'b0;
            exc_d       = 1'b0;
            exc_code_d  = '0;
            bad_vaddr_d = '0;
        end else if (!StallD) begin
            pc_add_4_d = PC_add_4F;
            pc_d       = pc_f;
            valid_d    = 1'b1;
            // Only a real branch/jump currently in decode makes the next fetch a delay slot.
            delay_d    = valid_q & (BranchD | JumpD);
            if (misaligned_f) begin
                exc_d       = 1'b1;
                exc_code_d  = ADEL_CODE;
                bad_vaddr_d = pc_f;
                instr_d     = '0;
            end else begin
                exc_d       = 1'b0;
                exc_code_d  = '0;
                bad_vaddr_d = '0;
                instr_d     = InstrF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q     <= '0;
            pc_add_4_q  <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            delay_q     <= 1'b0;
            exc_q       <= 1'b0;
            exc_code_q  <= '0;
            bad_vaddr_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_add_4_q  <= pc_add_4_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            delay_q     <= delay_d;
            exc_q       <= exc_d;
            exc_code_q  <= exc_code_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign InstrD       = instr_q;
    assign PC_add_4D    = pc_add_4_q;
    assign PCD          = pc_q;
    assign ValidD       = valid_q;
    assign InDelaySlotD = delay_q;
    assign ExcD         = exc_q;
    assign ExcCodeD     = exc_code_q;
    assign BadVAddrD    = bad_vaddr_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg: reset, load, stall, flush, delay slot, AdEL.
module tb_if_id_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             StallD;
    logic             FlushD;
    logic [WIDTH-1:0] PC_add_4F;
    logic [WIDTH-1:0] InstrF;
    logic             BranchD;
    logic             JumpD;
    logic [WIDTH-1:0] InstrD;
    logic [WIDTH-1:0] PC_add_4D;
    logic [WIDTH-1:0] PCD;
    logic             ValidD;
    logic             InDelaySlotD;
    logic             ExcD;
    logic [4:0]       ExcCodeD;
    logic [WIDTH-1:0] BadVAddrD;

    int n_checks;
    int n_fail;

    if_id_reg #(.WIDTH(WIDTH), .ADEL_CODE(5'h04)) dut (
        .clk          (clk),
        .rst          (rst),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PC_add_4F    (PC_add_4F),
        .InstrF       (InstrF),
        .BranchD      (BranchD),
        .JumpD        (JumpD),
        .InstrD       (InstrD),
        .PC_add_4D    (PC_add_4D),
        .PCD          (PCD),
        .ValidD       (ValidD),
        .InDelaySlotD (InDelaySlotD),
        .ExcD         (ExcD),
        .ExcCodeD     (ExcCodeD),
        .BadVAddrD    (BadVAddrD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                             input logic [31:0] pc, input logic valid, input logic slot,
                             input logic exc, input logic [4:0] code, input logic [31:0] bad);
        check({tag, ".InstrD"},       InstrD,            instr);
        check({tag, ".PC_add_4D"},    PC_add_4D,         pc4);
        check({tag, ".PCD"},          PCD,               pc);
        check({tag, ".ValidD"},       32'(ValidD),       32'(valid));
        check({tag, ".InDelaySlotD"}, 32'(InDelaySlotD), 32'(slot));
        check({tag, ".ExcD"},         32'(ExcD),         32'(exc));
        check({tag, ".ExcCodeD"},     32'(ExcCodeD),     32'(code));
        check({tag, ".BadVAddrD"},    BadVAddrD,         bad);
    endtask

    task automatic drive_f(input logic [31:0] pc4, input logic [31:0] instr);
        PC_add_4F = pc4;
        InstrF    = instr;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        BranchD   = 1'b0;
        JumpD     = 1'b0;
        drive_f(32'h4, 32'h24080001);

        // Reset holds everything at zero even across a clock edge.
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);

        // First load after release.
        #2 rst = 1'b1;
        step();
        check_all("load1", 32'h24080001, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        // Load then stall for three edges while F keeps changing.
        drive_f(32'h8, 32'h11111111);
        step();
        check_all("load2", 32'h11111111, 32'h8, 32'h4, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_f(32'h100 + 32'(i) * 32'h4, 32'hA0000000 + 32'(i));
            step();
            check("stall.PCD",    PCD,         32'h4);
            check("stall.InstrD", InstrD,      32'h11111111);
            check("stall.ValidD", 32'(ValidD), 32'h1);
        end
        StallD = 1'b0;
        drive_f(32'hC, 32'h22222222);
        step();
        check_all("unstall", 32'h22222222, 32'hC, 32'h8, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        // Flush overrides a simultaneous stall.
        StallD = 1'b1;
        FlushD = 1'b1;
        drive_f(32'h40, 32'h33333333);
        step();
        check_all("flush+stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
        StallD = 1'b0;
        FlushD = 1'b0;
        drive_f(32'h10, 32'h33333333);
        step();
        check_all("after_flush", 32'h33333333, 32'h10, 32'hC, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        // Valid branch in ID marks the next load as its delay slot.
        BranchD = 1'b1;
        drive_f(32'h14, 32'h44444444);
        step();
        check_all("slot_beq", 32'h44444444, 32'h14, 32'h10, 1'b1, 1'b1, 1'b0, 5'h0, 32'h0);

        // Two consecutive flushes give two bubbles; a branch flag on a bubble creates no slot.
        FlushD = 1'b1;
        step();
        check("flush1.ValidD", 32'(ValidD), 32'h0);
        step();
        check("flush2.ValidD", 32'(ValidD), 32'h0);
        FlushD = 1'b0;
        drive_f(32'h18, 32'h55555555);
        step();
        check_all("bubble_branch", 32'h55555555, 32'h18, 32'h14, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        // Jump followed by a stall: the slot flag is set on the edge the slot finally loads.
        BranchD = 1'b0;
        JumpD   = 1'b1;
        StallD  = 1'b1;
        drive_f(32'h1C, 32'h66666666);
        step();
        check("jstall.InDelaySlotD", 32'(InDelaySlotD), 32'h0);
        check("jstall.PCD",          PCD,               32'h14);
        StallD = 1'b0;
        step();
        check_all("slot_jump", 32'h66666666, 32'h1C, 32'h18, 1'b1, 1'b1, 1'b0, 5'h0, 32'h0);
        JumpD = 1'b0;

        // Misaligned fetch raises AdEL and discards the fetched word.
        drive_f(32'h00000406, 32'h77777777);
        step();
        check_all("adel", 32'h0, 32'h406, 32'h402, 1'b1, 1'b0, 1'b1, 5'h04, 32'h402);

        // PC+4 of zero wraps; the wrapped address is aligned.
        drive_f(32'h0, 32'h88888888);
        step();
        check_all("wrap", 32'h88888888, 32'h0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        drive_f(32'h00000405, 32'h99999999);
        step();
        check_all("adel_odd", 32'h0, 32'h405, 32'h401, 1'b1, 1'b0, 1'b1, 5'h04, 32'h401);

        // Asynchronous reset mid-cycle while stalled clears outputs before the next edge.
        drive_f(32'h20, 32'hAAAAAAAA);
        step();
        check("pre_rst.ValidD", 32'(ValidD), 32'h1);
        StallD = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
        step();
        check("rst_hold.ValidD", 32'(ValidD), 32'h0);

        // No stall survives reset: release with inputs idle and load normally.
        StallD = 1'b0;
        #2 rst = 1'b1;
        drive_f(32'h24, 32'hBBBBBBBB);
        step();
        check_all("post_rst", 32'hBBBBBBBB, 32'h24, 32'h20, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
